// File: rtl/ysyx_25040109_idu_pipe.sv
// Queued instruction decode stage: decodes IFU beats on entry and holds
// decoded bundles in a DEPTH-entry FIFO feeding the EXU.
module ysyx_25040109_idu_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned RV_M      = 1,
  parameter int unsigned RV_ZICSR  = 1,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [31:0]          out_inst,
  output logic [4:0]           rd_addr,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  output logic [XLEN-1:0]      imm,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  output logic [11:0]          csr_addr,
  output logic                 reg_write_en,
  output logic                 inst_invalid,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic            reg_write_en;
    logic            inst_invalid;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           dec;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic             legal, wb;
  logic [31:0]      imm32;
  logic [6:0]       opc, f7;
  logic [2:0]       f3;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Combinational decode of the incoming beat
  always_comb begin
    legal = 1'b0;
    wb    = 1'b0;
    imm32 = '0;
    opc   = in_inst[6:0];
    f3    = in_inst[14:12];
    f7    = in_inst[31:25];
    case (opc)
      OP_LUI, OP_AUIPC: begin
        legal = 1'b1;
        wb    = 1'b1;
        imm32 = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        legal = 1'b1;
        wb    = 1'b1;
        imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        legal = (f3 == 3'b000);
        wb    = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_LOAD: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        wb    = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010};
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        legal = !(f3 inside {3'b010, 3'b011});
        imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_IMM: begin
        wb    = 1'b1;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        case (f3)
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OP_OP: begin
        wb    = 1'b1;
        legal = (f7 == 7'b0000000)
             || ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101))
             || ((f7 == 7'b0000001) && (RV_M != 0));
      end
      OP_SYSTEM: begin
        if (in_inst == INST_ECALL || in_inst == INST_EBREAK) begin
          legal = 1'b1;
        end else if (RV_ZICSR != 0) begin
          if (in_inst == INST_MRET) begin
            legal = 1'b1;
          end else if (f3 != 3'b000 && f3 != 3'b100) begin
            legal = 1'b1;
            wb    = 1'b1;
            if (f3[2]) imm32 = {27'b0, in_inst[19:15]};
          end
        end
      end
      default: legal = 1'b0;
    endcase

    dec.pc           = in_pc;
    dec.inst         = in_inst;
    dec.inst_invalid = !legal;
    dec.reg_write_en = legal && wb && (in_inst[11:7] != 5'd0);
    dec.imm          = legal ? XLEN'($signed(imm32)) : '0;
  end

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // FIFO state and illegal counter; flush drops queue contents only
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ill_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= next_ptr(wr_ptr);
        if (dec.inst_invalid && ill_count != '1) ill_count <= ill_count + ILL_CNT_W'(1);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_pc       = mem[rd_ptr].pc;
  assign out_inst     = mem[rd_ptr].inst;
  assign imm          = mem[rd_ptr].imm;
  assign reg_write_en = mem[rd_ptr].reg_write_en;
  assign inst_invalid = mem[rd_ptr].inst_invalid;
  assign rd_addr      = out_inst[11:7];
  assign rs1_addr     = out_inst[19:15];
  assign rs2_addr     = out_inst[24:20];
  assign funct3       = out_inst[14:12];
  assign funct7       = out_inst[31:25];
  assign csr_addr     = out_inst[31:20];

endmodule

// File: tb/tb_ysyx_25040109_idu_pipe.sv
// Bench for ysyx_25040109_idu_pipe: a full-featured instance (a) and one with
// M/Zicsr disabled and a 2-bit illegal counter (b) share the same stimulus.
module tb_ysyx_25040109_idu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready_a, out_valid_a, rwe_a, inv_a;
  logic [31:0] out_pc_a, out_inst_a, imm_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [2:0]  f3_a;
  logic [6:0]  f7_a;
  logic [11:0] csr_a;
  logic [7:0]  ill_a;

  logic        in_ready_b, out_valid_b, rwe_b, inv_b;
  logic [31:0] out_pc_b, out_inst_b, imm_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [2:0]  f3_b;
  logic [6:0]  f7_b;
  logic [11:0] csr_b;
  logic [1:0]  ill_b;

  always #5 clk = ~clk;

  ysyx_25040109_idu_pipe dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .out_inst(out_inst_a), .rd_addr(rd_a), .rs1_addr(rs1_a),
    .rs2_addr(rs2_a), .imm(imm_a), .funct3(f3_a), .funct7(f7_a), .csr_addr(csr_a),
    .reg_write_en(rwe_a), .inst_invalid(inv_a), .ill_count(ill_a)
  );

  ysyx_25040109_idu_pipe #(.RV_M(0), .RV_ZICSR(0), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .out_inst(out_inst_b), .rd_addr(rd_b), .rs1_addr(rs1_b),
    .rs2_addr(rs2_b), .imm(imm_b), .funct3(f3_b), .funct7(f7_b), .csr_addr(csr_b),
    .reg_write_en(rwe_b), .inst_invalid(inv_b), .ill_count(ill_b)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic        rwe;
    logic        inv_a;
    logic        inv_b;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    vec_t        v;
  } sb_t;

  vec_t        vecs [17];
  sb_t         q [$];
  int          errors = 0;
  int          checks = 0;
  int          cnt_a = 0;
  int          cnt_b = 0;
  logic [31:0] pc_next = 32'h8000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the scoreboard head and occupancy model
  task automatic check_state();
    chk("in_ready_a", 64'(in_ready_a), 64'(q.size() < 2));
    chk("out_valid_a", 64'(out_valid_a), 64'(q.size() != 0));
    chk("in_ready_b", 64'(in_ready_b), 64'(q.size() < 2));
    chk("out_valid_b", 64'(out_valid_b), 64'(q.size() != 0));
    chk("ill_count_a", 64'(ill_a), 64'(cnt_a));
    chk("ill_count_b", 64'(ill_b), 64'(cnt_b));
    if (q.size() != 0) begin
      sb_t e;
      e = q[0];
      chk("out_pc_a", 64'(out_pc_a), 64'(e.pc));
      chk("out_inst_a", 64'(out_inst_a), 64'(e.v.inst));
      chk("imm_a", 64'(imm_a), 64'(e.v.imm));
      chk("rwe_a", 64'(rwe_a), 64'(e.v.rwe));
      chk("inv_a", 64'(inv_a), 64'(e.v.inv_a));
      chk("rd_a", 64'(rd_a), 64'(e.v.inst[11:7]));
      chk("rs1_a", 64'(rs1_a), 64'(e.v.inst[19:15]));
      chk("rs2_a", 64'(rs2_a), 64'(e.v.inst[24:20]));
      chk("funct3_a", 64'(f3_a), 64'(e.v.inst[14:12]));
      chk("funct7_a", 64'(f7_a), 64'(e.v.inst[31:25]));
      chk("csr_a", 64'(csr_a), 64'(e.v.inst[31:20]));
      chk("out_pc_b", 64'(out_pc_b), 64'(e.pc));
      chk("inv_b", 64'(inv_b), 64'(e.v.inv_b));
      chk("imm_b", 64'(imm_b), e.v.inv_b ? 64'd0 : 64'(e.v.imm));
      chk("rwe_b", 64'(rwe_b), e.v.inv_b ? 64'd0 : 64'(e.v.rwe));
    end
  endtask

  task automatic check_zero();
    chk("rst out_valid_a", 64'(out_valid_a), 64'd0);
    chk("rst in_ready_a", 64'(in_ready_a), 64'd1);
    chk("rst out_inst_a", 64'(out_inst_a), 64'd0);
    chk("rst out_pc_a", 64'(out_pc_a), 64'd0);
    chk("rst imm_a", 64'(imm_a), 64'd0);
    chk("rst rwe_a", 64'(rwe_a), 64'd0);
    chk("rst inv_a", 64'(inv_a), 64'd0);
    chk("rst ill_a", 64'(ill_a), 64'd0);
    chk("rst out_valid_b", 64'(out_valid_b), 64'd0);
    chk("rst inv_b", 64'(inv_b), 64'd0);
    chk("rst ill_b", 64'(ill_b), 64'd0);
  endtask

  // One cycle: check the current state, drive new inputs, advance the model
  task automatic cycle(input int idx, input logic v, input logic rdy, input logic fl, input logic rs);
    logic push, pop;
    @(negedge clk);
    check_state();
    rst       = rs;
    flush     = fl;
    in_valid  = v;
    out_ready = rdy;
    in_inst   = vecs[idx].inst;
    in_pc     = pc_next;
    push      = v && (q.size() < 2);
    pop       = (q.size() != 0) && rdy;
    if (rs) begin
      q.delete();
      cnt_a = 0;
      cnt_b = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc_next, vecs[idx]});
        if (vecs[idx].inv_a && cnt_a < 255) cnt_a++;
        if (vecs[idx].inv_b && cnt_b < 3) cnt_b++;
        pc_next = pc_next + 32'd4;
      end
    end
  endtask

  initial begin
    //            inst          imm           rwe   inv_a inv_b
    vecs[0]  = '{32'h0050_0093, 32'h0000_0005, 1'b1, 1'b0, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h0220_8033, 32'h0000_0000, 1'b0, 1'b0, 1'b1}; // mul x0,x1,x2
    vecs[2]  = '{32'h3410_2573, 32'h0000_0000, 1'b1, 1'b0, 1'b1}; // csrrs x10,mepc,x0
    vecs[3]  = '{32'h3002_d073, 32'h0000_0005, 1'b0, 1'b0, 1'b1}; // csrrwi x0,mstatus,5
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{32'h1234_52B7, 32'h1234_5000, 1'b1, 1'b0, 1'b0}; // lui x5
    vecs[7]  = '{32'hFE20_AE23, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0}; // sw x2,-4(x1)
    vecs[8]  = '{32'hFE00_0CE3, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0}; // beq x0,x0,-8
    vecs[9]  = '{32'h0010_00EF, 32'h0000_0800, 1'b1, 1'b0, 1'b0}; // jal x1,2048
    vecs[10] = '{32'h0000_0073, 32'h0000_0000, 1'b0, 1'b0, 1'b0}; // ecall
    vecs[11] = '{32'h3020_0073, 32'h0000_0000, 1'b0, 1'b0, 1'b1}; // mret
    vecs[12] = '{32'h0000_2063, 32'h0000_0000, 1'b0, 1'b1, 1'b1}; // branch f3=010
    vecs[13] = '{32'h4011_D193, 32'h0000_0401, 1'b1, 1'b0, 1'b0}; // srai x3,x3,1
    vecs[14] = '{32'h4011_9193, 32'h0000_0000, 1'b0, 1'b1, 1'b1}; // slli with bad f7
    vecs[15] = '{32'hFFF1_2203, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}; // lw x4,-1(x2)
    vecs[16] = '{32'h0000_1017, 32'h0000_1000, 1'b0, 1'b0, 1'b0}; // auipc x0

    cycle(0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 check_zero();

    // Single push with one-cycle latency, then pop
    cycle(0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Table sweep, streaming one beat per cycle
    for (int i = 0; i < 17; i++) cycle(i, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill with back-pressure, third beat held, then drain in order
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(6, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(9, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(9, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(9, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(9, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Flush while full with an illegal push in the same cycle
    cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(6, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(4, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(13, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Saturation of the 2-bit counter, then reset clears it
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 check_zero();
    for (int i = 0; i < 5; i++) cycle(5, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 check_zero();
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
